// File: rtl/debug_trace_controller_pkg.sv
// Shared types and default sizing for the commit-trace capture block.
package DebugTraceTypes;

    localparam int DEF_COMMIT_WIDTH = 2;
    localparam int DEF_TRACE_DEPTH  = 64;
    localparam int DEF_PC_WIDTH     = 32;
    localparam int DEF_TS_WIDTH     = 16;
    localparam int DEF_PTR_WIDTH    = $clog2(DEF_TRACE_DEPTH);
    localparam int LANE_CNT_WIDTH   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } TraceState;

    typedef logic [DEF_PTR_WIDTH-1:0] TracePtr;
    typedef logic [DEF_PTR_WIDTH:0]   TraceCount;

    typedef struct packed {
        logic [LANE_CNT_WIDTH-1:0] laneCount;
        logic [DEF_PC_WIDTH-1:0]   pc;
        logic [DEF_TS_WIDTH-1:0]   ts;
    } TraceEntry;

endpackage

// File: rtl/debug_trace_controller_if.sv
// Pipeline-observe, host-command and trace-read signals of the trace controller.
interface debug_trace_controller_if
    import DebugTraceTypes::*;
#(
    parameter int COMMIT_WIDTH = DEF_COMMIT_WIDTH,
    parameter int TRACE_DEPTH  = DEF_TRACE_DEPTH,
    parameter int PC_WIDTH     = DEF_PC_WIDTH,
    parameter int TS_WIDTH     = DEF_TS_WIDTH
);
    localparam int PTR_W   = $clog2(TRACE_DEPTH);
    localparam int ENTRY_W = LANE_CNT_WIDTH + PC_WIDTH + TS_WIDTH;

    logic [COMMIT_WIDTH-1:0]               cmtValid;
    logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0] cmtPC;
    logic                                  cfgWe;
    logic [PC_WIDTH-1:0]                   cfgTrigPC;
    logic [PTR_W:0]                        cfgPostCount;
    logic                                  cmdArm;
    logic                                  cmdForce;
    logic                                  cmdClear;
    logic [PTR_W-1:0]                      rdIndex;
    logic [ENTRY_W-1:0]                    rdData;
    logic [1:0]                            state;
    logic [PTR_W:0]                        entryCount;
    logic [PTR_W-1:0]                      trigIndex;

    modport master (
        output cmtValid, cmtPC, cfgWe, cfgTrigPC, cfgPostCount,
               cmdArm, cmdForce, cmdClear, rdIndex,
        input  rdData, state, entryCount, trigIndex
    );

    modport slave (
        input  cmtValid, cmtPC, cfgWe, cfgTrigPC, cfgPostCount,
               cmdArm, cmdForce, cmdClear, rdIndex,
        output rdData, state, entryCount, trigIndex
    );

endinterface

// File: rtl/debug_trace_ram.sv
// Simple dual-port trace RAM: synchronous write port, registered read port.
module debug_trace_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 50
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wrAddr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rdData <= '0;
        end else begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/debug_trace_controller.sv
// Commit-trace capture: arm, trigger on PC match or force, capture post-trigger
// entries into a circular RAM, then freeze for oldest-first host readout.
module debug_trace_controller
    import DebugTraceTypes::*;
#(
    parameter int COMMIT_WIDTH = DEF_COMMIT_WIDTH,
    parameter int TRACE_DEPTH  = DEF_TRACE_DEPTH,
    parameter int PC_WIDTH     = DEF_PC_WIDTH,
    parameter int TS_WIDTH     = DEF_TS_WIDTH
) (
    input logic                     clk,
    input logic                     rstN,
    debug_trace_controller_if.slave dbg
);
    localparam int PTR_W   = $clog2(TRACE_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = LANE_CNT_WIDTH + PC_WIDTH + TS_WIDTH;

    TraceState           stateQ, stateD;
    logic [PTR_W-1:0]    wrPtrQ, wrPtrD;
    logic [PTR_W-1:0]    trigPtrQ, trigPtrD;
    logic [CNT_W-1:0]    entryCountQ, entryCountD;
    logic [CNT_W-1:0]    postCntQ, postCntD;
    logic [TS_WIDTH-1:0] tsQ;
    logic [PC_WIDTH-1:0] cfgTrigPCQ;
    logic [CNT_W-1:0]    cfgPostCountQ;

    logic [LANE_CNT_WIDTH-1:0] laneCount;
    logic [PC_WIDTH-1:0]       lastPC;
    logic                      pcMatch;
    logic                      anyValid;
    logic                      writeEn;
    logic [PTR_W-1:0]          oldestPtr;
    logic [PTR_W-1:0]          rdAddr;
    logic [ENTRY_W-1:0]        wrData;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        laneCount = '0;
        lastPC    = '0;
        pcMatch   = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (dbg.cmtValid[i]) begin
                laneCount = laneCount + LANE_CNT_WIDTH'(1);
                lastPC    = dbg.cmtPC[i];
                if (dbg.cmtPC[i] == cfgTrigPCQ) begin
                    pcMatch = 1'b1;
                end
            end
        end
    end

    assign anyValid = |dbg.cmtValid;
    assign wrData   = {laneCount, lastPC, tsQ};

    always_comb begin
        stateD      = stateQ;
        wrPtrD      = wrPtrQ;
        trigPtrD    = trigPtrQ;
        entryCountD = entryCountQ;
        postCntD    = postCntQ;
        writeEn     = 1'b0;

        if (dbg.cmdClear) begin
            stateD      = ST_IDLE;
            entryCountD = '0;
        end else begin
            writeEn = anyValid && (stateQ == ST_ARMED || stateQ == ST_POST);
            if (writeEn) begin
                wrPtrD = wrPtrQ + PTR_W'(1);
                if (entryCountQ != CNT_W'(TRACE_DEPTH)) begin
                    entryCountD = entryCountQ + CNT_W'(1);
                end
            end

            unique case (stateQ)
                ST_IDLE: begin
                    if (dbg.cmdArm) begin
                        stateD      = ST_ARMED;
                        wrPtrD      = '0;
                        entryCountD = '0;
                        postCntD    = '0;
                    end
                end
                ST_ARMED: begin
                    if (dbg.cmdForce || pcMatch) begin
                        // A commit-less force points at the newest existing entry.
                        if (anyValid) begin
                            trigPtrD = wrPtrQ;
                        end else if (entryCountQ == '0) begin
                            trigPtrD = '0;
                        end else begin
                            trigPtrD = wrPtrQ - PTR_W'(1);
                        end
                        postCntD = cfgPostCountQ;
                        stateD   = (cfgPostCountQ == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (writeEn) begin
                        postCntD = postCntQ - CNT_W'(1);
                        if (postCntQ == CNT_W'(1)) begin
                            stateD = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    stateD = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateQ      <= ST_IDLE;
            wrPtrQ      <= '0;
            trigPtrQ    <= '0;
            entryCountQ <= '0;
            postCntQ    <= '0;
            tsQ         <= '0;
        end else begin
            stateQ      <= stateD;
            wrPtrQ      <= wrPtrD;
            trigPtrQ    <= trigPtrD;
            entryCountQ <= entryCountD;
            postCntQ    <= postCntD;
            tsQ         <= tsQ + TS_WIDTH'(1);
        end
    end

    // Config is frozen while a capture is in flight.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cfgTrigPCQ    <= '0;
            cfgPostCountQ <= '0;
        end else if (dbg.cfgWe && (stateQ == ST_IDLE || stateQ == ST_DONE)) begin
            cfgTrigPCQ    <= dbg.cfgTrigPC;
            cfgPostCountQ <= dbg.cfgPostCount;
        end
    end

    assign oldestPtr = (entryCountQ == CNT_W'(TRACE_DEPTH)) ? wrPtrQ : '0;
    assign rdAddr    = oldestPtr + dbg.rdIndex;

    debug_trace_ram #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk    (clk),
        .rstN   (rstN),
        .we     (writeEn),
        .wrAddr (wrPtrQ),
        .wrData (wrData),
        .rdAddr (rdAddr),
        .rdData (dbg.rdData)
    );

    assign dbg.state      = stateQ;
    assign dbg.entryCount = entryCountQ;
    assign dbg.trigIndex  = trigPtrQ - oldestPtr;

endmodule

// File: tb/tb_debug_trace_controller.sv
// Directed bench for debug_trace_controller: one task per scenario, inline checks.
module tb_debug_trace_controller;
    import DebugTraceTypes::*;

    logic clk;
    logic rstN;
    int   assertCount;
    int   failCount;

    debug_trace_controller_if #(
        .COMMIT_WIDTH (2), .TRACE_DEPTH (64), .PC_WIDTH (32), .TS_WIDTH (16)
    ) dbg ();

    debug_trace_controller #(
        .COMMIT_WIDTH (2), .TRACE_DEPTH (64), .PC_WIDTH (32), .TS_WIDTH (16)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .dbg  (dbg.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idleInputs();
        dbg.cmtValid     = '0;
        dbg.cmtPC        = '0;
        dbg.cfgWe        = 1'b0;
        dbg.cfgTrigPC    = '0;
        dbg.cfgPostCount = '0;
        dbg.cmdArm       = 1'b0;
        dbg.cmdForce     = 1'b0;
        dbg.cmdClear     = 1'b0;
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic cycle(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                         input logic frc, input logic arm, input logic clr);
        dbg.cmtValid = v;
        dbg.cmtPC[0] = p0;
        dbg.cmtPC[1] = p1;
        dbg.cmdForce = frc;
        dbg.cmdArm   = arm;
        dbg.cmdClear = clr;
        @(posedge clk);
        #1;
        idleInputs();
    endtask

    task automatic setConfig(input logic [31:0] trigPC, input logic [6:0] post);
        dbg.cfgWe        = 1'b1;
        dbg.cfgTrigPC    = trigPC;
        dbg.cfgPostCount = post;
        @(posedge clk);
        #1;
        idleInputs();
    endtask

    task automatic readEntry(input int idx, output TraceEntry e);
        dbg.rdIndex = 6'(idx);
        @(posedge clk);
        #1;
        e = TraceEntry'(dbg.rdData);
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        idleInputs();
        dbg.rdIndex = '0;
        repeat (3) @(posedge clk);
        #1;
        assertCount++;
        if (dbg.state !== 2'd0) begin
            failCount++; $display("FAIL reset_state: got %0d expected 0", dbg.state);
        end
        assertCount++;
        if (dbg.entryCount !== 7'd0) begin
            failCount++; $display("FAIL reset_entryCount: got %0d expected 0", dbg.entryCount);
        end
        assertCount++;
        if (dbg.trigIndex !== 6'd0) begin
            failCount++; $display("FAIL reset_trigIndex: got %0d expected 0", dbg.trigIndex);
        end
        assertCount++;
        if (dbg.rdData !== '0) begin
            failCount++; $display("FAIL reset_rdData: got %h expected 0", dbg.rdData);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_force_trigger();
        TraceEntry e;
        setConfig(32'hFFFF_FFF0, 7'd1);
        cycle(2'b00, 0, 0, 0, 1, 0);
        assertCount++;
        if (dbg.state !== 2'd1) begin
            failCount++; $display("FAIL force_armed: got %0d expected 1", dbg.state);
        end
        cycle(2'b01, 32'h100, 0, 0, 0, 0);
        cycle(2'b01, 32'h104, 0, 0, 0, 0);
        cycle(2'b01, 32'h108, 0, 1, 0, 0);
        assertCount++;
        if (dbg.state !== 2'd2) begin
            failCount++; $display("FAIL force_post: got %0d expected 2", dbg.state);
        end
        cycle(2'b01, 32'h10C, 0, 0, 0, 0);
        assertCount++;
        if (dbg.state !== 2'd3) begin
            failCount++; $display("FAIL force_done: got %0d expected 3", dbg.state);
        end
        assertCount++;
        if (dbg.entryCount !== 7'd4) begin
            failCount++; $display("FAIL force_entryCount: got %0d expected 4", dbg.entryCount);
        end
        assertCount++;
        if (dbg.trigIndex !== 6'd2) begin
            failCount++; $display("FAIL force_trigIndex: got %0d expected 2", dbg.trigIndex);
        end
        readEntry(3, e);
        assertCount++;
        if (e.pc !== 32'h10C || e.laneCount !== 2'd1) begin
            failCount++; $display("FAIL force_read3: got pc %h cnt %0d expected pc 10c cnt 1", e.pc, e.laneCount);
        end
        cycle(2'b01, 32'h110, 0, 0, 1, 0);
        assertCount++;
        if (dbg.state !== 2'd3 || dbg.entryCount !== 7'd4) begin
            failCount++; $display("FAIL done_holds: got state %0d count %0d expected 3 4", dbg.state, dbg.entryCount);
        end
    endtask

    task automatic test_dual_lane();
        TraceEntry e;
        cycle(2'b00, 0, 0, 0, 0, 1);
        assertCount++;
        if (dbg.state !== 2'd0 || dbg.entryCount !== 7'd0) begin
            failCount++; $display("FAIL clear_done: got state %0d count %0d expected 0 0", dbg.state, dbg.entryCount);
        end
        setConfig(32'h204, 7'd0);
        cycle(2'b00, 0, 0, 0, 1, 0);
        cycle(2'b11, 32'h200, 32'h204, 0, 0, 0);
        assertCount++;
        if (dbg.state !== 2'd3) begin
            failCount++; $display("FAIL dual_done: got %0d expected 3", dbg.state);
        end
        assertCount++;
        if (dbg.trigIndex !== 6'd0 || dbg.entryCount !== 7'd1) begin
            failCount++; $display("FAIL dual_idx: got trig %0d count %0d expected 0 1", dbg.trigIndex, dbg.entryCount);
        end
        readEntry(0, e);
        assertCount++;
        if (e.pc !== 32'h204 || e.laneCount !== 2'd2) begin
            failCount++; $display("FAIL dual_entry: got pc %h cnt %0d expected pc 204 cnt 2", e.pc, e.laneCount);
        end
    endtask

    task automatic test_wrap();
        TraceEntry e;
        cycle(2'b00, 0, 0, 0, 0, 1);
        setConfig(32'h1000 + 32'd400, 7'd10);
        cycle(2'b00, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 110; k++) begin
            cycle(2'b01, 32'h1000 + 32'(4 * k), 0, 0, 0, 0);
            if (k == 100 || k == 109) begin
                assertCount++;
                if (dbg.state !== 2'd2) begin
                    failCount++; $display("FAIL wrap_post_k%0d: got %0d expected 2", k, dbg.state);
                end
            end
        end
        assertCount++;
        if (dbg.state !== 2'd3) begin
            failCount++; $display("FAIL wrap_done: got %0d expected 3", dbg.state);
        end
        assertCount++;
        if (dbg.entryCount !== 7'd64) begin
            failCount++; $display("FAIL wrap_entryCount: got %0d expected 64", dbg.entryCount);
        end
        assertCount++;
        if (dbg.trigIndex !== 6'd53) begin
            failCount++; $display("FAIL wrap_trigIndex: got %0d expected 53", dbg.trigIndex);
        end
        readEntry(0, e);
        assertCount++;
        if (e.pc !== 32'h1000 + 32'd188) begin
            failCount++; $display("FAIL wrap_oldest: got %h expected %h", e.pc, 32'h1000 + 32'd188);
        end
        readEntry(53, e);
        assertCount++;
        if (e.pc !== 32'h1000 + 32'd400) begin
            failCount++; $display("FAIL wrap_trigEntry: got %h expected %h", e.pc, 32'h1000 + 32'd400);
        end
        readEntry(63, e);
        assertCount++;
        if (e.pc !== 32'h1000 + 32'd440) begin
            failCount++; $display("FAIL wrap_newest: got %h expected %h", e.pc, 32'h1000 + 32'd440);
        end
    endtask

    task automatic test_force_no_commit();
        cycle(2'b00, 0, 0, 0, 0, 1);
        setConfig(32'hFFFF_FFF0, 7'd2);
        cycle(2'b00, 0, 0, 0, 1, 0);
        cycle(2'b01, 32'h6000, 0, 0, 0, 0);
        cycle(2'b01, 32'h6004, 0, 0, 0, 0);
        cycle(2'b00, 0, 0, 1, 0, 0);
        cycle(2'b01, 32'h6008, 0, 0, 0, 0);
        cycle(2'b01, 32'h600C, 0, 0, 0, 0);
        assertCount++;
        if (dbg.state !== 2'd3 || dbg.entryCount !== 7'd4) begin
            failCount++; $display("FAIL fnc_done: got state %0d count %0d expected 3 4", dbg.state, dbg.entryCount);
        end
        assertCount++;
        if (dbg.trigIndex !== 6'd1) begin
            failCount++; $display("FAIL fnc_trigIndex: got %0d expected 1", dbg.trigIndex);
        end
    endtask

    task automatic test_clear_force();
        cycle(2'b00, 0, 0, 0, 0, 1);
        setConfig(32'h3000, 7'd5);
        cycle(2'b00, 0, 0, 0, 1, 0);
        cycle(2'b01, 32'h3100, 0, 0, 0, 0);
        cycle(2'b01, 32'h3104, 0, 0, 0, 0);
        setConfig(32'h3200, 7'd0);
        cycle(2'b01, 32'h3200, 0, 0, 0, 0);
        assertCount++;
        if (dbg.state !== 2'd1) begin
            failCount++; $display("FAIL cfg_locked: got %0d expected 1", dbg.state);
        end
        cycle(2'b01, 32'h3204, 0, 1, 0, 1);
        assertCount++;
        if (dbg.state !== 2'd0 || dbg.entryCount !== 7'd0) begin
            failCount++; $display("FAIL clear_force: got state %0d count %0d expected 0 0", dbg.state, dbg.entryCount);
        end
        cycle(2'b00, 0, 0, 0, 1, 0);
        cycle(2'b01, 32'h3000, 0, 0, 0, 0);
        assertCount++;
        if (dbg.state !== 2'd2) begin
            failCount++; $display("FAIL cfg_kept: got %0d expected 2", dbg.state);
        end
    endtask

    task automatic test_reset_mid();
        TraceEntry e;
        cycle(2'b01, 32'h3008, 0, 0, 0, 0);
        cycle(2'b01, 32'h300C, 0, 0, 0, 0);
        rstN = 1'b0;
        #1;
        assertCount++;
        if (dbg.state !== 2'd0 || dbg.entryCount !== 7'd0 || dbg.trigIndex !== 6'd0) begin
            failCount++; $display("FAIL async_reset: got state %0d count %0d trig %0d expected 0 0 0",
                                  dbg.state, dbg.entryCount, dbg.trigIndex);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        cycle(2'b00, 0, 0, 0, 1, 0);
        cycle(2'b01, 32'h4000, 0, 0, 0, 0);
        cycle(2'b01, 32'h4004, 0, 0, 0, 0);
        cycle(2'b01, 32'h4008, 0, 1, 0, 0);
        assertCount++;
        if (dbg.state !== 2'd3 || dbg.entryCount !== 7'd3 || dbg.trigIndex !== 6'd2) begin
            failCount++; $display("FAIL rearm: got state %0d count %0d trig %0d expected 3 3 2",
                                  dbg.state, dbg.entryCount, dbg.trigIndex);
        end
        readEntry(0, e);
        assertCount++;
        if (e.pc !== 32'h4000) begin
            failCount++; $display("FAIL rearm_idx0: got %h expected 4000", e.pc);
        end
    endtask

    task automatic test_idle_gap();
        TraceEntry e0, e1, e2;
        cycle(2'b00, 0, 0, 0, 0, 1);
        setConfig(32'h5008, 7'd0);
        cycle(2'b00, 0, 0, 0, 1, 0);
        cycle(2'b01, 32'h5000, 0, 0, 0, 0);
        repeat (5) cycle(2'b00, 0, 0, 0, 0, 0);
        assertCount++;
        if (dbg.entryCount !== 7'd1 || dbg.state !== 2'd1) begin
            failCount++; $display("FAIL gap_nowrite: got count %0d state %0d expected 1 1", dbg.entryCount, dbg.state);
        end
        cycle(2'b01, 32'h5004, 0, 0, 0, 0);
        cycle(2'b10, 0, 32'h5008, 0, 0, 0);
        assertCount++;
        if (dbg.state !== 2'd3 || dbg.entryCount !== 7'd3) begin
            failCount++; $display("FAIL gap_done: got state %0d count %0d expected 3 3", dbg.state, dbg.entryCount);
        end
        readEntry(0, e0);
        readEntry(1, e1);
        readEntry(2, e2);
        assertCount++;
        if (16'(e1.ts - e0.ts) !== 16'd6) begin
            failCount++; $display("FAIL gap_delta: got %0d expected 6", 16'(e1.ts - e0.ts));
        end
        assertCount++;
        if (16'(e2.ts - e1.ts) !== 16'd1 || e2.pc !== 32'h5008) begin
            failCount++; $display("FAIL gap_next: got delta %0d pc %h expected 1 5008", 16'(e2.ts - e1.ts), e2.pc);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        test_reset();
        test_force_trigger();
        test_dual_lane();
        test_wrap();
        test_force_no_commit();
        test_clear_force();
        test_reset_mid();
        test_idle_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
